// File: rtl/exu_lpwbck_pkg.sv
// Long-pipe writeback shared definitions.
// Sizes, tag/data types and the RUN/DRAIN state encoding.
package exu_lpwbck_pkg;

    localparam int E203_OITF_DEPTH  = 2;
    localparam int E203_ITAG_WIDTH  = 1;
    localparam int E203_RFIDX_WIDTH = 5;
    localparam int E203_PC_SIZE     = 32;
    localparam int E203_XLEN        = 32;

    localparam logic E203_LPWBCK_ST_RUN   = 1'b0;
    localparam logic E203_LPWBCK_ST_DRAIN = 1'b1;

    typedef logic [E203_ITAG_WIDTH-1:0]  itag_t;
    typedef logic [E203_RFIDX_WIDTH-1:0] rfidx_t;
    typedef logic [E203_PC_SIZE-1:0]     pc_t;
    typedef logic [E203_XLEN-1:0]        xlen_t;

    typedef enum logic {
        ST_RUN   = E203_LPWBCK_ST_RUN,
        ST_DRAIN = E203_LPWBCK_ST_DRAIN
    } lpwbck_st_e;

endpackage

// File: rtl/exu_lpwbck_if.sv
// Long-pipe writeback handshake bundle.
// LSU/FPU completion inputs, regfile write and exception outputs.
interface exu_lpwbck_if;
    import exu_lpwbck_pkg::*;

    logic   lsu_wbck_i_valid;
    logic   lsu_wbck_i_ready;
    itag_t  lsu_wbck_i_itag;
    xlen_t  lsu_wbck_i_wdat;
    logic   lsu_wbck_i_err;

    logic   fpu_wbck_i_valid;
    logic   fpu_wbck_i_ready;
    itag_t  fpu_wbck_i_itag;
    xlen_t  fpu_wbck_i_wdat;
    logic   fpu_wbck_i_err;

    logic   rf_wbck_o_valid;
    logic   rf_wbck_o_ready;
    xlen_t  rf_wbck_o_wdat;
    rfidx_t rf_wbck_o_rdidx;
    logic   rf_wbck_o_rdfpu;

    logic   excp_o_valid;
    logic   excp_o_ready;
    pc_t    excp_o_pc;

    modport slave (
        input  lsu_wbck_i_valid, lsu_wbck_i_itag,
        input  lsu_wbck_i_wdat, lsu_wbck_i_err,
        output lsu_wbck_i_ready,
        input  fpu_wbck_i_valid, fpu_wbck_i_itag,
        input  fpu_wbck_i_wdat, fpu_wbck_i_err,
        output fpu_wbck_i_ready,
        output rf_wbck_o_valid, rf_wbck_o_wdat,
        output rf_wbck_o_rdidx, rf_wbck_o_rdfpu,
        input  rf_wbck_o_ready,
        output excp_o_valid, excp_o_pc,
        input  excp_o_ready
    );

    modport master (
        output lsu_wbck_i_valid, lsu_wbck_i_itag,
        output lsu_wbck_i_wdat, lsu_wbck_i_err,
        input  lsu_wbck_i_ready,
        output fpu_wbck_i_valid, fpu_wbck_i_itag,
        output fpu_wbck_i_wdat, fpu_wbck_i_err,
        input  fpu_wbck_i_ready,
        input  rf_wbck_o_valid, rf_wbck_o_wdat,
        input  rf_wbck_o_rdidx, rf_wbck_o_rdfpu,
        output rf_wbck_o_ready,
        input  excp_o_valid, excp_o_pc,
        output excp_o_ready
    );

endinterface

// File: rtl/exu_lpwbck_rbuf.sv
// Result buffer: one slot per ITAG holding vld/err/wdat.
// Two set ports (LSU, FPU), one clear port, one read port.
module exu_lpwbck_rbuf
    import exu_lpwbck_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  set_a,
    input  itag_t set_a_idx,
    input  logic  set_a_err,
    input  xlen_t set_a_wdat,
    input  logic  set_b,
    input  itag_t set_b_idx,
    input  logic  set_b_err,
    input  xlen_t set_b_wdat,
    input  logic  clr,
    input  itag_t clr_idx,
    input  itag_t rd_idx,
    output logic [E203_OITF_DEPTH-1:0] vld,
    output logic  rd_vld,
    output logic  rd_err,
    output xlen_t rd_wdat
);

    logic [E203_OITF_DEPTH-1:0] vld_nxt;
    logic  err_q  [E203_OITF_DEPTH];
    xlen_t wdat_q [E203_OITF_DEPTH];

    // Set and clear never target the same slot: a slot is
    // only accepted into while its vld is low.
    always_comb begin
        vld_nxt = vld;
        if (clr)
            vld_nxt[clr_idx] = 1'b0;
        if (set_a)
            vld_nxt[set_a_idx] = 1'b1;
        if (set_b)
            vld_nxt[set_b_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld <= '0;
        else
            vld <= vld_nxt;
    end

    // Payload is qualified by vld, so it carries no reset.
    always_ff @(posedge clk) begin
        if (set_a) begin
            err_q[set_a_idx]  <= set_a_err;
            wdat_q[set_a_idx] <= set_a_wdat;
        end
        if (set_b) begin
            err_q[set_b_idx]  <= set_b_err;
            wdat_q[set_b_idx] <= set_b_wdat;
        end
    end

    assign rd_vld  = vld[rd_idx];
    assign rd_err  = err_q[rd_idx];
    assign rd_wdat = wdat_q[rd_idx];

endmodule

// File: rtl/exu_lpwbck.sv
// Long-pipe writeback: reorders LSU/FPU completions to OITF order.
// Ports: clk/rst, wb (completions, rf write, exception), oitf_* head.
module exu_lpwbck
    import exu_lpwbck_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    exu_lpwbck_if.slave wb,
    input  logic   oitf_empty,
    input  itag_t  oitf_ret_ptr,
    input  rfidx_t oitf_ret_rdidx,
    input  logic   oitf_ret_rdwen,
    input  logic   oitf_ret_rdfpu,
    input  pc_t    oitf_ret_pc,
    output logic   oitf_ret_ena
);

    logic [E203_OITF_DEPTH-1:0] vld;
    logic       same_tag;
    logic       lsu_acc;
    logic       fpu_acc;
    logic       head_vld;
    logic       head_err;
    xlen_t      head_wdat;
    logic       head_rdy;
    logic       rf_vld;
    logic       ex_vld;
    logic       ret;
    lpwbck_st_e st_q;
    lpwbck_st_e st_d;

    // LSU wins when both sources target the same slot.
    assign same_tag = wb.lsu_wbck_i_valid
                    & wb.fpu_wbck_i_valid
                    & (wb.lsu_wbck_i_itag == wb.fpu_wbck_i_itag);

    assign wb.lsu_wbck_i_ready = ~vld[wb.lsu_wbck_i_itag];
    assign wb.fpu_wbck_i_ready = ~vld[wb.fpu_wbck_i_itag]
                               & ~same_tag;

    assign lsu_acc = wb.lsu_wbck_i_valid & wb.lsu_wbck_i_ready;
    assign fpu_acc = wb.fpu_wbck_i_valid & wb.fpu_wbck_i_ready;

    exu_lpwbck_rbuf u_rbuf (
        .clk        (clk),
        .rst        (rst),
        .set_a      (lsu_acc),
        .set_a_idx  (wb.lsu_wbck_i_itag),
        .set_a_err  (wb.lsu_wbck_i_err),
        .set_a_wdat (wb.lsu_wbck_i_wdat),
        .set_b      (fpu_acc),
        .set_b_idx  (wb.fpu_wbck_i_itag),
        .set_b_err  (wb.fpu_wbck_i_err),
        .set_b_wdat (wb.fpu_wbck_i_wdat),
        .clr        (ret),
        .clr_idx    (oitf_ret_ptr),
        .rd_idx     (oitf_ret_ptr),
        .vld        (vld),
        .rd_vld     (head_vld),
        .rd_err     (head_err),
        .rd_wdat    (head_wdat)
    );

    assign head_rdy = head_vld & ~oitf_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            st_q <= ST_RUN;
        else
            st_q <= st_d;
    end

    // After an exception is taken, everything still in the
    // OITF belongs to the flushed stream and retires silently.
    always_comb begin
        st_d   = st_q;
        rf_vld = 1'b0;
        ex_vld = 1'b0;
        ret    = 1'b0;
        unique case (st_q)
            ST_RUN: begin
                if (head_rdy) begin
                    if (head_err) begin
                        ex_vld = 1'b1;
                        ret    = wb.excp_o_ready;
                        if (wb.excp_o_ready)
                            st_d = ST_DRAIN;
                    end else if (oitf_ret_rdwen) begin
                        rf_vld = 1'b1;
                        ret    = wb.rf_wbck_o_ready;
                    end else begin
                        ret = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                ret = head_rdy;
                if (oitf_empty)
                    st_d = ST_RUN;
            end
        endcase
    end

    assign oitf_ret_ena       = ret;
    assign wb.rf_wbck_o_valid = rf_vld;
    assign wb.rf_wbck_o_wdat  = head_wdat;
    assign wb.rf_wbck_o_rdidx = oitf_ret_rdidx;
    assign wb.rf_wbck_o_rdfpu = oitf_ret_rdfpu;
    assign wb.excp_o_valid    = ex_vld;
    assign wb.excp_o_pc       = oitf_ret_pc;

endmodule

// File: tb/tb_exu_lpwbck.sv
// Bench for exu_lpwbck: directed scenarios then random traffic
// against an OITF queue + completion-table reference model.
module tb_exu_lpwbck;
    import exu_lpwbck_pkg::*;

    localparam int D = E203_OITF_DEPTH;

    logic   clk = 1'b0;
    logic   rst;
    logic   oitf_empty;
    itag_t  oitf_ret_ptr;
    rfidx_t oitf_ret_rdidx;
    logic   oitf_ret_rdwen;
    logic   oitf_ret_rdfpu;
    pc_t    oitf_ret_pc;
    logic   oitf_ret_ena;

    always #5 clk = ~clk;

    exu_lpwbck_if bus ();

    exu_lpwbck u_dut (
        .clk            (clk),
        .rst            (rst),
        .wb             (bus),
        .oitf_empty     (oitf_empty),
        .oitf_ret_ptr   (oitf_ret_ptr),
        .oitf_ret_rdidx (oitf_ret_rdidx),
        .oitf_ret_rdwen (oitf_ret_rdwen),
        .oitf_ret_rdfpu (oitf_ret_rdfpu),
        .oitf_ret_pc    (oitf_ret_pc),
        .oitf_ret_ena   (oitf_ret_ena)
    );

    typedef struct {
        itag_t  tag;
        rfidx_t rd;
        logic   wen;
        logic   fpu;
        pc_t    pc;
    } ent_t;

    // Reference model: in-order OITF contents, per-tag results
    // that have completed but not retired, and flush mode.
    ent_t  oq [$];
    logic  done [D];
    logic  derr [D];
    xlen_t dwd  [D];
    bit    drain;
    int    nxt_tag;

    bit    lv, fv, le, fe, rr, er;
    itag_t lt, ft;
    xlen_t lw, fw;

    int    checks, fails;
    int    exp_ret;
    int    obs_rf, obs_ex, obs_ret, obs_lacc, obs_facc;
    xlen_t wr_log [$];
    xlen_t last_wd;
    rfidx_t last_rd;
    pc_t   last_pc;
    logic  last_lrdy, last_frdy, last_rfv;

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic mdl_reset();
        oq.delete();
        for (int i = 0; i < D; i++) begin
            done[i] = 1'b0;
            derr[i] = 1'b0;
            dwd[i]  = '0;
        end
        drain   = 1'b0;
        nxt_tag = 0;
    endtask

    task automatic alloc(rfidx_t rd, bit wen, bit fpu, pc_t pc);
        ent_t e;
        e.tag = itag_t'(nxt_tag);
        e.rd  = rd;
        e.wen = wen;
        e.fpu = fpu;
        e.pc  = pc;
        oq.push_back(e);
        nxt_tag = (nxt_tag + 1) % D;
    endtask

    task automatic drv(ent_t h);
        oitf_empty            = (oq.size() == 0);
        oitf_ret_ptr          = h.tag;
        oitf_ret_rdidx        = h.rd;
        oitf_ret_rdwen        = h.wen;
        oitf_ret_rdfpu        = h.fpu;
        oitf_ret_pc           = h.pc;
        bus.lsu_wbck_i_valid  = lv;
        bus.lsu_wbck_i_itag   = lt;
        bus.lsu_wbck_i_wdat   = lw;
        bus.lsu_wbck_i_err    = le;
        bus.fpu_wbck_i_valid  = fv;
        bus.fpu_wbck_i_itag   = ft;
        bus.fpu_wbck_i_wdat   = fw;
        bus.fpu_wbck_i_err    = fe;
        bus.rf_wbck_o_ready   = rr;
        bus.excp_o_ready      = er;
    endtask

    // One clock: drive at negedge, check at negedge+1, then
    // advance the model to what the next posedge must do.
    task automatic step();
        ent_t h;
        bit hok, elr, efr, erf, eex, eret;
        h = '{tag: '0, rd: '0, wen: 1'b0, fpu: 1'b0, pc: '0};
        @(negedge clk);
        if (oq.size() > 0)
            h = oq[0];
        drv(h);
        #1;
        elr = !done[lt];
        efr = !done[ft] && !(lv && fv && lt == ft);
        chk("lsu_rdy", 64'(bus.lsu_wbck_i_ready), 64'(elr));
        chk("fpu_rdy", 64'(bus.fpu_wbck_i_ready), 64'(efr));
        hok  = (oq.size() > 0) && done[h.tag];
        erf  = 1'b0;
        eex  = 1'b0;
        eret = 1'b0;
        if (hok) begin
            if (drain) begin
                eret = 1'b1;
            end else if (derr[h.tag]) begin
                eex  = 1'b1;
                eret = er;
            end else if (h.wen) begin
                erf  = 1'b1;
                eret = rr;
            end else begin
                eret = 1'b1;
            end
        end
        chk("rf_ex_ret",
            64'({bus.rf_wbck_o_valid, bus.excp_o_valid,
                 oitf_ret_ena}),
            64'({erf, eex, eret}));
        if (erf) begin
            chk("rf_wdat", 64'(bus.rf_wbck_o_wdat),
                64'(dwd[h.tag]));
            chk("rf_rdidx", 64'(bus.rf_wbck_o_rdidx), 64'(h.rd));
            chk("rf_rdfpu", 64'(bus.rf_wbck_o_rdfpu), 64'(h.fpu));
        end
        if (eex)
            chk("excp_pc", 64'(bus.excp_o_pc), 64'(h.pc));

        last_lrdy = bus.lsu_wbck_i_ready;
        last_frdy = bus.fpu_wbck_i_ready;
        last_rfv  = bus.rf_wbck_o_valid;
        last_wd   = bus.rf_wbck_o_wdat;
        if (bus.rf_wbck_o_valid && rr) begin
            obs_rf++;
            wr_log.push_back(bus.rf_wbck_o_wdat);
            last_rd = bus.rf_wbck_o_rdidx;
        end
        if (bus.excp_o_valid && er) begin
            obs_ex++;
            last_pc = bus.excp_o_pc;
        end
        if (oitf_ret_ena)
            obs_ret++;
        if (lv && bus.lsu_wbck_i_ready)
            obs_lacc++;
        if (fv && bus.fpu_wbck_i_ready)
            obs_facc++;

        if (drain && oq.size() == 0)
            drain = 1'b0;
        if (eret) begin
            done[h.tag] = 1'b0;
            void'(oq.pop_front());
            exp_ret++;
        end
        if (eex && er)
            drain = 1'b1;
        if (lv && elr) begin
            done[lt] = 1'b1;
            derr[lt] = le;
            dwd[lt]  = lw;
        end
        if (fv && efr) begin
            done[ft] = 1'b1;
            derr[ft] = fe;
            dwd[ft]  = fw;
        end
    endtask

    task automatic idle();
        lv = 1'b0;
        fv = 1'b0;
        le = 1'b0;
        fe = 1'b0;
    endtask

    initial begin
        ent_t z;
        int   r0, f0, x0, a0, b0;
        itag_t pend [$];

        checks = 0;
        fails  = 0;
        exp_ret = 0;
        obs_rf = 0; obs_ex = 0; obs_ret = 0;
        obs_lacc = 0; obs_facc = 0;
        mdl_reset();
        idle();
        lt = '0; ft = '0; lw = '0; fw = '0;
        rr = 1'b1;
        er = 1'b1;
        z = '{tag: '0, rd: '0, wen: 1'b0, fpu: 1'b0, pc: '0};
        rst = 1'b1;
        drv(z);

        // reset values
        @(negedge clk);
        #1;
        chk("rst_rfv", 64'(bus.rf_wbck_o_valid), 64'd0);
        chk("rst_exv", 64'(bus.excp_o_valid), 64'd0);
        chk("rst_ret", 64'(oitf_ret_ena), 64'd0);
        chk("rst_lrdy", 64'(bus.lsu_wbck_i_ready), 64'd1);
        chk("rst_frdy", 64'(bus.fpu_wbck_i_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // single LSU completion -> rf write next cycle
        r0 = obs_ret;
        alloc(5'd5, 1'b1, 1'b0, 32'h100);
        lv = 1'b1; lt = 1'd0; lw = 32'h1234;
        step();
        idle();
        step();
        step();
        chk("r19_wdat", 64'(wr_log[wr_log.size()-1]), 64'h1234);
        chk("r19_rdidx", 64'(last_rd), 64'd5);
        chk("r19_ret", 64'(obs_ret - r0), 64'd1);

        // no-write head retires without output
        r0 = obs_ret;
        x0 = obs_rf;
        alloc(5'd0, 1'b0, 1'b0, 32'h104);
        lv = 1'b1; lt = 1'd1; lw = 32'h0;
        step();
        idle();
        step();
        chk("nowr_rf", 64'(obs_rf - x0), 64'd0);
        chk("nowr_ret", 64'(obs_ret - r0), 64'd1);

        // out-of-order completion, in-order writeback
        x0 = obs_rf;
        alloc(5'd10, 1'b1, 1'b0, 32'h108);
        alloc(5'd11, 1'b1, 1'b1, 32'h10c);
        fv = 1'b1; ft = 1'd1; fw = 32'hB1;
        step();
        idle();
        step();
        chk("r20_hold", 64'(obs_rf - x0), 64'd0);
        lv = 1'b1; lt = 1'd0; lw = 32'hA0;
        step();
        idle();
        step();
        step();
        chk("r20_cnt", 64'(obs_rf - x0), 64'd2);
        chk("r20_first", 64'(wr_log[wr_log.size()-2]), 64'hA0);
        chk("r20_second", 64'(wr_log[wr_log.size()-1]), 64'hB1);

        // same-tag collision: LSU wins, FPU waits for slot free
        alloc(5'd12, 1'b1, 1'b0, 32'h110);
        alloc(5'd13, 1'b1, 1'b0, 32'h114);
        lv = 1'b1; lt = 1'd1; lw = 32'hC1;
        fv = 1'b1; ft = 1'd1; fw = 32'hF1;
        step();
        chk("r21_lrdy", 64'(last_lrdy), 64'd1);
        chk("r21_frdy", 64'(last_frdy), 64'd0);
        lt = 1'd0; lw = 32'hC0;
        step();
        lv = 1'b0;
        step();
        alloc(5'd0, 1'b0, 1'b0, 32'h118);
        f0 = obs_facc;
        step();
        chk("r21_blocked", 64'(obs_facc - f0), 64'd0);
        alloc(5'd14, 1'b1, 1'b1, 32'h11c);
        step();
        chk("r21_facc", 64'(obs_facc - f0), 64'd1);
        fv = 1'b0;
        lv = 1'b1; lt = 1'd0; lw = 32'h0;
        step();
        idle();
        step();
        step();
        chk("r21_fwd", 64'(wr_log[wr_log.size()-1]), 64'hF1);

        // exception head, then drain, then back to RUN
        r0 = obs_ret; x0 = obs_rf; a0 = obs_ex;
        f0 = obs_facc; b0 = obs_lacc;
        alloc(5'd1, 1'b1, 1'b0, 32'h80000010);
        alloc(5'd2, 1'b1, 1'b0, 32'h80000014);
        lv = 1'b1; lt = 1'd0; lw = 32'hDEAD; le = 1'b1;
        fv = 1'b1; ft = 1'd1; fw = 32'h5555;
        step();
        chk("dual_lacc", 64'(obs_lacc - b0), 64'd1);
        chk("dual_facc", 64'(obs_facc - f0), 64'd1);
        idle();
        step();
        chk("r22_pc", 64'(last_pc), 64'h80000010);
        step();
        step();
        chk("r22_norf", 64'(obs_rf - x0), 64'd0);
        chk("r22_ex", 64'(obs_ex - a0), 64'd1);
        chk("r22_ret", 64'(obs_ret - r0), 64'd2);
        alloc(5'd4, 1'b1, 1'b0, 32'h120);
        lv = 1'b1; lt = 1'd0; lw = 32'h4444;
        step();
        idle();
        step();
        chk("r22_run", 64'(wr_log[wr_log.size()-1]), 64'h4444);

        // rf backpressure holds payload and retire
        alloc(5'd9, 1'b1, 1'b0, 32'h124);
        lv = 1'b1; lt = 1'd1; lw = 32'h2323;
        rr = 1'b0;
        step();
        idle();
        r0 = obs_ret;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r23_valid", 64'(last_rfv), 64'd1);
            chk("r23_wd", 64'(last_wd), 64'h2323);
        end
        chk("r23_noret", 64'(obs_ret - r0), 64'd0);
        rr = 1'b1;
        step();
        chk("r23_ret", 64'(obs_ret - r0), 64'd1);

        // async reset while rf valid is high
        alloc(5'd8, 1'b1, 1'b0, 32'h128);
        lv = 1'b1; lt = 1'd0; lw = 32'h77;
        rr = 1'b0;
        step();
        idle();
        step();
        chk("r24_pre", 64'(last_rfv), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("r24_rfv", 64'(bus.rf_wbck_o_valid), 64'd0);
        chk("r24_exv", 64'(bus.excp_o_valid), 64'd0);
        chk("r24_ret", 64'(oitf_ret_ena), 64'd0);
        chk("r24_lrdy", 64'(bus.lsu_wbck_i_ready), 64'd1);
        chk("r24_frdy", 64'(bus.fpu_wbck_i_ready), 64'd1);
        mdl_reset();
        rr = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // random traffic
        exp_ret = 0;
        obs_ret = 0;
        for (int c = 0; c < 4000; c++) begin
            pend.delete();
            foreach (oq[k])
                if (!done[oq[k].tag])
                    pend.push_back(oq[k].tag);
            idle();
            if (pend.size() > 0 && ($urandom % 2) == 0) begin
                lv = 1'b1;
                lt = pend[$urandom_range(pend.size() - 1)];
                lw = $urandom;
                le = (($urandom % 8) == 0);
            end
            if (pend.size() > 0 && ($urandom % 2) == 0) begin
                fv = 1'b1;
                ft = pend[$urandom_range(pend.size() - 1)];
                fw = $urandom;
                fe = (($urandom % 8) == 0);
            end
            rr = (($urandom % 4) != 0);
            er = (($urandom % 4) != 0);
            step();
            if (oq.size() < D && !drain && ($urandom % 2) == 0)
                alloc(rfidx_t'($urandom), ($urandom % 4) != 0,
                      1'($urandom), $urandom);
        end
        chk("rand_ret", 64'(obs_ret), 64'(exp_ret));

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, fails);
        $finish;
    end

endmodule
